impix_system_leds_output: RTL and testbench



---
 rtl/impix_system_leds_output.sv | 155 +++++++++++++++
 tb/tb_impix_system_leds_output.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/impix_system_leds_output.sv
// Purpose : Avalon-MM LED output port with DATA, atomic set/clear and a hardware blink engine.
// Latency : register writes take effect on the write edge; readdata is registered (1 cycle, no wait states).
// Backpress: none; the slave always accepts and never stalls the bus.
//
// Ports:
//   clk, reset_n            - system clock, asynchronous active-low reset
//   address[2:0]            - word address (0 DATA, 1 BLINK_EN, 2 BLINK_PERIOD, 4 OUTSET, 5 OUTCLEAR)
//   chipselect, write_n     - a write happens when chipselect=1 and write_n=0
//   writedata[31:0]         - write data; bits above the target register width are dropped
//   readdata[31:0]          - registered, zero-extended read of the addressed register
//   out_port[DATA_WIDTH-1:0]- LED drive: DATA with blink-enabled bits XORed by the blink phase
module impix_system_leds_output #(
  parameter int unsigned                DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0]      RESET_VALUE  = '0,
  parameter int unsigned                PERIOD_WIDTH = 24,
  parameter logic [PERIOD_WIDTH-1:0]    PERIOD_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // Counter reload value out of reset: the first phase lasts a full period.
  localparam logic [PERIOD_WIDTH-1:0] CNT_RESET =
    (PERIOD_RESET == '0) ? '0 : PERIOD_RESET - PERIOD_WIDTH'(1);

  // Registers
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_blink_en;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic                    r_ph;
  logic [31:0]             r_readdata;

  // Bus decode
  logic                    w_wr;
  logic                    w_wr_data;
  logic                    w_wr_blink_en;
  logic                    w_wr_period;
  logic                    w_wr_set;
  logic                    w_wr_clr;
  logic [DATA_WIDTH-1:0]   w_wdata_d;
  logic [PERIOD_WIDTH-1:0] w_wdata_p;
  logic [PERIOD_WIDTH-1:0] w_new_cnt;
  logic [31:0]             w_rdata;
  logic                    w_unused_wdata;

  assign w_wr          = chipselect & ~write_n;
  assign w_wr_data     = w_wr && (address == ADDR_DATA);
  assign w_wr_blink_en = w_wr && (address == ADDR_BLINK_EN);
  assign w_wr_period   = w_wr && (address == ADDR_PERIOD);
  assign w_wr_set      = w_wr && (address == ADDR_OUTSET);
  assign w_wr_clr      = w_wr && (address == ADDR_OUTCLEAR);

  // Upper writedata bits are deliberately dropped for narrow registers.
  assign w_wdata_d      = writedata[DATA_WIDTH-1:0];
  assign w_wdata_p      = writedata[PERIOD_WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  // Counter preload on a period write; a zero period parks the counter at 0.
  assign w_new_cnt = (w_wdata_p == '0) ? '0 : w_wdata_p - PERIOD_WIDTH'(1);

  // DATA register. Only one address is decoded per cycle, so direct write,
  // set and clear are mutually exclusive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_wr_data) begin
      r_data <= w_wdata_d;
    end else if (w_wr_set) begin
      r_data <= r_data | w_wdata_d;
    end else if (w_wr_clr) begin
      r_data <= r_data & ~w_wdata_d;
    end
  end

  // BLINK_EN register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_en <= '0;
    end else if (w_wr_blink_en) begin
      r_blink_en <= w_wdata_d;
    end
  end

  // BLINK_PERIOD register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= PERIOD_RESET;
    end else if (w_wr_period) begin
      r_period <= w_wdata_p;
    end
  end

  // Blink engine. A period write restarts the sequence with ph=0 and takes
  // priority over the normal count step. The counter runs from period-1 down
  // to 0, so ph toggles every 'period' cycles; period-1 never overflows even
  // at the all-ones maximum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= CNT_RESET;
      r_ph  <= 1'b0;
    end else if (w_wr_period) begin
      r_cnt <= w_new_cnt;
      r_ph  <= 1'b0;
    end else if (r_period == '0) begin
      r_cnt <= '0;
      r_ph  <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt <= r_period - PERIOD_WIDTH'(1);
      r_ph  <= ~r_ph;
    end else begin
      r_cnt <= r_cnt - PERIOD_WIDTH'(1);
    end
  end

  // Read mux: zero-extended, independent of chipselect. Write-only and
  // reserved addresses read as 0.
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:     w_rdata[DATA_WIDTH-1:0]   = r_data;
      ADDR_BLINK_EN: w_rdata[DATA_WIDTH-1:0]   = r_blink_en;
      ADDR_PERIOD:   w_rdata[PERIOD_WIDTH-1:0] = r_period;
      default:       w_rdata = '0;
    endcase
  end

  // Sampled every edge from pre-update register values, so a read that
  // coincides with a write returns the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;

  // Purely register-driven, so the LEDs never see bus glitches.
  assign out_port = r_data ^ (r_blink_en & {DATA_WIDTH{r_ph}});

endmodule

// File: tb/tb_impix_system_leds_output.sv
// Purpose : scoreboard bench for impix_system_leds_output (RESET_VALUE=A5, PERIOD_WIDTH=4).
// Latency : expectations are tagged with the cycle in which the DUT must show them.
// Backpress: n/a; the monitor drains every expectation whose cycle has arrived.
module tb_impix_system_leds_output;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  impix_system_leds_output #(
    .DATA_WIDTH   (8),
    .RESET_VALUE  (8'hA5),
    .PERIOD_WIDTH (4),
    .PERIOD_RESET (4'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed blink sequences.
  // Period 4, DATA=00, EN=01, starting right after the period write.
  logic [7:0] tbl_p4 [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
  // DATA=81 written as ph returns to 0; ph goes back to 1 four cycles later.
  logic [7:0] tbl_inv [6] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h80, 8'h80};
  // Period 2 written while ph=1: ph cleared at once, then toggles every 2.
  logic [7:0] tbl_p2  [8] = '{8'h81, 8'h81, 8'h80, 8'h80, 8'h81, 8'h81, 8'h80, 8'h80};

  function automatic void push(input int at, input bit rd, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc   = at;
    e.is_rd = rd;
    e.val   = v;
    e.nm    = nm;
    sb_q.push_back(e);
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e   = sb_q.pop_front();
      mon_act = mon_e.is_rd ? readdata : {24'h0, out_port};
      n_chk++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got %h, expected %h (due cycle %0d)",
                 mon_e.nm, cyc, mon_act, mon_e.val, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int k;
    int m;
    int p;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    // ---- Reset and asynchronous mid-cycle reset ----
    tick(); tick();
    push(cyc, 1'b0, 32'hA5, "rst_out");
    push(cyc, 1'b1, 32'h0,  "rst_rd");
    reset_n = 1'b1;
    push(cyc + 1, 1'b0, 32'h3C, "wr_data_out");
    push(cyc + 1, 1'b1, 32'hA5, "rd_prewrite");
    bus_wr(3'd0, 32'h3C);
    push(cyc + 1, 1'b1, 32'h3C, "rd_postwrite");
    tick(); tick();
    reset_n = 1'b0;               // mid-cycle, no clock edge before the check
    push(cyc, 1'b0, 32'hA5, "async_rst_out");
    push(cyc, 1'b1, 32'h0,  "async_rst_rd");
    tick();
    reset_n = 1'b1;
    address = 3'd0;
    push(cyc + 1, 1'b1, 32'hA5, "rd_data_rst");
    tick();

    // ---- Set / clear / reserved ----
    push(cyc + 1, 1'b0, 32'h0F, "data_0f");
    bus_wr(3'd0, 32'h0F);
    push(cyc + 1, 1'b0, 32'h3F, "outset");
    bus_wr(3'd4, 32'h30);
    push(cyc + 1, 1'b0, 32'h3C, "outclear");
    bus_wr(3'd5, 32'h03);
    address = 3'd4;
    push(cyc + 1, 1'b1, 32'h0, "rd_outset");
    tick();
    address = 3'd5;
    push(cyc + 1, 1'b1, 32'h0, "rd_outclear");
    tick();
    address = 3'd0;
    push(cyc + 1, 1'b1, 32'h3C, "rd_data_3c");
    tick();
    push(cyc + 1, 1'b0, 32'h3C, "wr_addr6_out");
    bus_wr(3'd6, 32'hFF);
    push(cyc + 1, 1'b1, 32'h0, "rd_addr6");
    tick();
    address = 3'd3;
    push(cyc + 1, 1'b1, 32'h0, "rd_addr3");
    tick();

    // ---- Bus protocol ----
    address    = 3'd0;
    writedata  = 32'hAA;
    write_n    = 1'b0;            // chipselect stays low
    push(cyc + 1, 1'b0, 32'h3C, "no_cs_write");
    tick();
    write_n    = 1'b1;
    push(cyc + 1, 1'b0, 32'h5A, "wide_wdata_out");
    push(cyc + 1, 1'b1, 32'h3C, "rd_same_cycle");
    bus_wr(3'd0, 32'hFFFF_FF5A);
    push(cyc + 1, 1'b1, 32'h5A, "rd_b2b");
    tick();

    // ---- Blink, period 4 ----
    push(cyc + 1, 1'b0, 32'h00, "data_00");
    bus_wr(3'd0, 32'h0);
    push(cyc + 1, 1'b0, 32'h00, "en_no_period");
    bus_wr(3'd1, 32'hFFFF_FF01);
    address = 3'd1;
    push(cyc + 1, 1'b1, 32'h01, "rd_blink_en");
    tick();
    k = cyc + 1;
    for (int i = 0; i < 16; i++) push(k + i, 1'b0, {24'h0, tbl_p4[i]}, "blink_p4");
    bus_wr(3'd2, 32'd4);
    repeat (15) tick();
    for (int i = 0; i < 6; i++) push(k + 16 + i, 1'b0, {24'h0, tbl_inv[i]}, "blink_inv");
    bus_wr(3'd0, 32'h81);
    repeat (5) tick();

    // ---- Period change mid-count, then disable ----
    m = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      push(m + i, 1'b0, {24'h0, tbl_p2[i]}, "blink_p2");
      if (i == 1) push(m + 1, 1'b1, 32'h2, "rd_period2");
    end
    bus_wr(3'd2, 32'd2);
    repeat (7) tick();
    for (int i = 0; i < 4; i++) begin
      push(m + 8 + i, 1'b0, 32'h81, "period0_hold");
      if (i == 1) push(m + 9, 1'b1, 32'h0, "rd_period0");
    end
    bus_wr(3'd2, 32'd0);
    repeat (3) tick();

    // ---- Max period 15 with PERIOD_WIDTH=4 ----
    push(cyc + 1, 1'b0, 32'h00, "data_00_b");
    bus_wr(3'd0, 32'h0);
    p = cyc + 1;
    push(p + 1,  1'b1, 32'h0F, "rd_period15");
    push(p + 14, 1'b0, 32'h00, "p15_before_t1");
    push(p + 15, 1'b0, 32'h01, "p15_toggle1");
    push(p + 29, 1'b0, 32'h01, "p15_before_t2");
    push(p + 30, 1'b0, 32'h00, "p15_toggle2");
    push(p + 44, 1'b0, 32'h00, "p15_before_t3");
    push(p + 45, 1'b0, 32'h01, "p15_toggle3");
    bus_wr(3'd2, 32'd15);
    repeat (50) tick();
    reset_n = 1'b0;
    push(cyc, 1'b0, 32'hA5, "midcount_rst_out");
    push(cyc, 1'b1, 32'h0,  "midcount_rst_rd");
    tick();
    reset_n = 1'b1;
    address = 3'd1;
    push(cyc + 1, 1'b1, 32'h0, "rd_en_after_rst");
    tick();
    address = 3'd2;
    push(cyc + 1, 1'b1, 32'h0, "rd_period_after_rst");
    tick();
    push(cyc + 1, 1'b0, 32'hA5, "out_after_rst");
    tick();

    // Drain with a bounded wait.
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
